// File: rtl/key_scan.sv
// 4x4 keypad scanner: rotates active-low rows, debounces a single-key press and
// its release, and reports each accepted key once.
//
// state       | meaning
// ST_SCAN     | rotating rows, sampling columns on the last dwell cycle
// ST_DB_PRESS | row frozen, counting stable cycles of the captured column
// ST_HELD     | key accepted, waiting for all columns to go high
// ST_DB_REL   | counting stable all-high cycles before resuming the scan
module key_scan #(
   parameter int DEBOUNCE_MS = 20
) (
   input  logic       CLK_1K,
   input  logic       RST,
   input  logic [3:0] col_in,
   output logic [3:0] row_out,
   output logic [3:0] key_value,
   output logic       flag,
   output logic       key_down
);

   localparam logic [1:0] ST_SCAN     = 2'd0;
   localparam logic [1:0] ST_DB_PRESS = 2'd1;
   localparam logic [1:0] ST_HELD     = 2'd2;
   localparam logic [1:0] ST_DB_REL   = 2'd3;
   localparam logic [7:0] DB_LAST     = 8'(DEBOUNCE_MS - 1);

   logic [3:0] r_col_m;
   logic [3:0] r_col_s;
   logic [1:0] r_state;
   logic [1:0] r_row;
   logic [1:0] r_dwell;
   logic [7:0] r_cnt;
   logic [1:0] r_cap_idx;
   logic [3:0] r_key_value;
   logic       r_flag;
   logic       r_key_down;

   logic       w_one_low;
   logic [1:0] w_col_idx;
   logic [3:0] w_cap_pat;
   logic [7:0] w_cnt_inc;
   logic [3:0] w_code;

   always_comb begin
      w_one_low = 1'b1;
      w_col_idx = 2'd0;
      case (r_col_s)
         4'b1110: w_col_idx = 2'd0;
         4'b1101: w_col_idx = 2'd1;
         4'b1011: w_col_idx = 2'd2;
         4'b0111: w_col_idx = 2'd3;
         default: w_one_low = 1'b0;
      endcase
   end

   assign w_cap_pat = ~(4'b0001 << r_cap_idx);
   assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

   // Row-major keypad legend; F is clear, E is equals, A..D are operators.
   always_comb begin
      w_code = 4'h0;
      case ({r_row, r_cap_idx})
         4'd0:  w_code = 4'h1;
         4'd1:  w_code = 4'h2;
         4'd2:  w_code = 4'h3;
         4'd3:  w_code = 4'hA;
         4'd4:  w_code = 4'h4;
         4'd5:  w_code = 4'h5;
         4'd6:  w_code = 4'h6;
         4'd7:  w_code = 4'hB;
         4'd8:  w_code = 4'h7;
         4'd9:  w_code = 4'h8;
         4'd10: w_code = 4'h9;
         4'd11: w_code = 4'hC;
         4'd12: w_code = 4'hF;
         4'd13: w_code = 4'h0;
         4'd14: w_code = 4'hE;
         default: w_code = 4'hD;
      endcase
   end

   always_ff @(posedge CLK_1K or negedge RST) begin
      if (!RST) begin
         r_col_m     <= 4'hF;
         r_col_s     <= 4'hF;
         r_state     <= ST_SCAN;
         r_row       <= 2'd0;
         r_dwell     <= 2'd0;
         r_cnt       <= 8'd0;
         r_cap_idx   <= 2'd0;
         r_key_value <= 4'h0;
         r_flag      <= 1'b0;
         r_key_down  <= 1'b0;
      end else begin
         r_col_m <= col_in;
         r_col_s <= r_col_m;
         r_flag  <= 1'b0;
         case (r_state)
            ST_SCAN: begin
               if (r_dwell == 2'd3) begin
                  if (w_one_low) begin
                     r_cap_idx <= w_col_idx;
                     r_cnt     <= 8'd0;
                     r_state   <= ST_DB_PRESS;
                  end else begin
                     r_row   <= r_row + 2'd1;
                     r_dwell <= 2'd0;
                  end
               end else begin
                  r_dwell <= r_dwell + 2'd1;
               end
            end
            ST_DB_PRESS: begin
               if (r_col_s == w_cap_pat) begin
                  r_cnt <= w_cnt_inc;
                  if (r_cnt >= DB_LAST) begin
                     r_state     <= ST_HELD;
                     r_flag      <= 1'b1;
                     r_key_value <= w_code;
                     r_key_down  <= 1'b1;
                  end
               end else begin
                  r_cnt   <= 8'd0;
                  r_state <= ST_SCAN;
                  r_dwell <= 2'd0;
               end
            end
            ST_HELD: begin
               if (r_col_s == 4'hF) begin
                  r_cnt   <= 8'd0;
                  r_state <= ST_DB_REL;
               end
            end
            ST_DB_REL: begin
               if (r_col_s == 4'hF) begin
                  r_cnt <= w_cnt_inc;
                  if (r_cnt >= DB_LAST) begin
                     r_state    <= ST_SCAN;
                     r_row      <= 2'd0;
                     r_dwell    <= 2'd0;
                     r_key_down <= 1'b0;
                  end
               end else begin
                  r_cnt   <= 8'd0;
                  r_state <= ST_HELD;
               end
            end
            default: r_state <= ST_SCAN;
         endcase
      end
   end

   assign row_out   = ~(4'b0001 << r_row);
   assign key_value = r_key_value;
   assign flag      = r_flag;
   assign key_down  = r_key_down;

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: a keypad matrix model drives the columns from row_out,
// expected key codes are queued at press time and matched on each flag.
module tb_key_scan;

   logic        CLK_1K = 1'b0;
   logic        RST    = 1'b0;
   logic [3:0]  col_in;
   logic [3:0]  row_out;
   logic [3:0]  key_value;
   logic        flag;
   logic        key_down;
   logic [15:0] keys = 16'h0000;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_flags  = 0;
   logic        prev_flag = 1'b0;
   logic [3:0]  exp_q[$];

   key_scan #(.DEBOUNCE_MS(4)) dut (
      .CLK_1K    (CLK_1K),
      .RST       (RST),
      .col_in    (col_in),
      .row_out   (row_out),
      .key_value (key_value),
      .flag      (flag),
      .key_down  (key_down)
   );

   always #5 CLK_1K = ~CLK_1K;

   // Pressed key at (r,c) pulls column c low while row r is driven low.
   always_comb begin
      col_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   always @(negedge CLK_1K) begin
      if (RST && flag) begin
         n_flags++;
         check_val("flag_single_cycle", 32'(prev_flag), 32'd0);
         check_val("key_down_on_flag", 32'(key_down), 32'd1);
         if (exp_q.size() > 0) check_val("key_value", 32'(key_value), 32'(exp_q.pop_front()));
         else check_val("spurious_flag", 32'(flag), 32'd0);
      end
      prev_flag = flag;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge CLK_1K);
         #1;
      end
   endtask

   task automatic wait_flag(input string tag, input int budget, output int waited);
      int f0;
      f0 = n_flags;
      waited = 0;
      while (n_flags == f0 && waited < budget) begin
         tick(1);
         waited++;
      end
      check_val(tag, 32'(n_flags - f0), 32'd1);
   endtask

   task automatic wait_release(input string tag, input int budget, output int waited);
      waited = 0;
      while (key_down && waited < budget) begin
         tick(1);
         waited++;
      end
      check_val(tag, 32'(key_down), 32'd0);
      check_val({tag, "_row0"}, 32'(row_out), 32'hE);
   endtask

   initial begin
      int w;
      int f0;
      int run;
      logic [3:0] exp_row;
      logic [3:0] seen_rows;

      tick(3);
      check_val("rst_row_out", 32'(row_out), 32'hE);
      check_val("rst_key_value", 32'(key_value), 32'h0);
      check_val("rst_flag", 32'(flag), 32'd0);
      check_val("rst_key_down", 32'(key_down), 32'd0);

      RST = 1'b1;
      for (int i = 0; i <= 16; i += 4) begin
         exp_row = ~(4'b0001 << (i % 4 == 0 ? (i / 4) % 4 : 0));
         check_val("scan_rotation", 32'(row_out), 32'(exp_row));
         if (i < 16) tick(4);
      end

      // Clean press of '8' (row2/col1)
      f0 = n_flags;
      keys[9] = 1'b1;
      exp_q.push_back(4'h8);
      wait_flag("s1_flag", 30, w);
      check_val("s1_latency_le23", 32'(w <= 23), 32'd1);
      tick(100 - w);
      check_val("s1_key_down", 32'(key_down), 32'd1);
      check_val("s1_key_value_hold", 32'(key_value), 32'h8);
      check_val("s1_flag_count", 32'(n_flags - f0), 32'd1);
      keys[9] = 1'b0;
      wait_release("s1_release", 20, w);

      // Bouncing press of 'A' (row0/col3)
      f0 = n_flags;
      for (int i = 0; i < 3; i++) begin
         keys[3] = 1'b1;
         tick(2);
         keys[3] = 1'b0;
         tick(2);
      end
      check_val("s2_no_flag_bounce", 32'(n_flags - f0), 32'd0);
      keys[3] = 1'b1;
      exp_q.push_back(4'hA);
      wait_flag("s2_flag", 30, w);
      keys[3] = 1'b0;
      wait_release("s2_release", 20, w);

      // Long hold of 'E' (row3/col2) with a bouncy release
      f0 = n_flags;
      keys[14] = 1'b1;
      exp_q.push_back(4'hE);
      wait_flag("s3_flag", 30, w);
      tick(200);
      check_val("s3_row_frozen", 32'(row_out), 32'h7);
      check_val("s3_key_down", 32'(key_down), 32'd1);
      for (int i = 0; i < 3; i++) begin
         keys[14] = 1'b0;
         tick(2);
         keys[14] = 1'b1;
         tick(2);
      end
      check_val("s3_held_after_bounce", 32'(key_down), 32'd1);
      keys[14] = 1'b0;
      wait_release("s3_release", 20, w);
      check_val("s3_release_delay", 32'(w >= 4 && w <= 8), 32'd1);
      check_val("s3_flag_count", 32'(n_flags - f0), 32'd1);

      // Two keys on row1: ignored until col2 lets go
      f0 = n_flags;
      seen_rows = 4'h0;
      keys[4] = 1'b1;
      keys[6] = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         seen_rows = seen_rows | ~row_out;
      end
      check_val("s4_no_flag_multi", 32'(n_flags - f0), 32'd0);
      check_val("s4_scan_continues", 32'(seen_rows), 32'hF);
      keys[6] = 1'b0;
      exp_q.push_back(4'h4);
      wait_flag("s4_flag", 30, w);
      keys[4] = 1'b0;
      wait_release("s4_release", 20, w);

      // '5' held, '9' pressed meanwhile
      f0 = n_flags;
      keys[5] = 1'b1;
      exp_q.push_back(4'h5);
      wait_flag("s5_flag5", 30, w);
      keys[10] = 1'b1;
      tick(30);
      check_val("s5_row_frozen", 32'(row_out), 32'hD);
      check_val("s5_key_value", 32'(key_value), 32'h5);
      check_val("s5_flag_count", 32'(n_flags - f0), 32'd1);
      keys[5] = 1'b0;
      keys[10] = 1'b0;
      wait_release("s5_release", 20, w);
      keys[10] = 1'b1;
      exp_q.push_back(4'h9);
      wait_flag("s5_flag9", 30, w);
      keys[10] = 1'b0;
      wait_release("s5_release9", 20, w);

      // Reset pulsed two cycles into a '1' press debounce
      f0 = n_flags;
      keys[0] = 1'b1;
      run = 0;
      w = 0;
      while (run < 5 && w < 60) begin
         tick(1);
         w++;
         if (row_out == 4'hE) run++;
         else run = 0;
      end
      check_val("s6_db_press_seen", 32'(run), 32'd5);
      tick(2);
      RST = 1'b0;
      tick(1);
      check_val("s6_rst_row_out", 32'(row_out), 32'hE);
      check_val("s6_rst_key_value", 32'(key_value), 32'h0);
      check_val("s6_rst_flag", 32'(flag), 32'd0);
      check_val("s6_rst_key_down", 32'(key_down), 32'd0);
      tick(1);
      keys[0] = 1'b0;
      RST = 1'b1;
      tick(30);
      check_val("s6_no_flag", 32'(n_flags - f0), 32'd0);
      check_val("s6_key_value", 32'(key_value), 32'h0);
      check_val("s6_key_down", 32'(key_down), 32'd0);

      check_val("leftover_expected", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
